// File: rtl/uart_key_decoder.sv
// UART key decoder: filters ASCII digits from the receiver into a FWFT key FIFO
// and keeps saturating drop statistics for parity errors, rejects and overflows.
module uart_key_decoder #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_ascii,
    input  logic             rx_parity_error,
    input  logic             rx_data_valid,
    output logic [3:0]       key_value,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             fifo_full,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] parity_err_cnt,
    output logic [CNT_W-1:0] reject_cnt,
    output logic [CNT_W-1:0] overflow_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_state_t;

    localparam logic [PTR_W:0]   OCC_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_state_t       state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic [PTR_W:0]   occ_nxt;
    logic [3:0]       mem [DEPTH];

    logic is_digit;
    logic par_evt;
    logic rej_evt;
    logic cand;
    logic push;
    logic pop;
    logic ovf_evt;

    assign is_digit = (rx_ascii >= 8'h30) && (rx_ascii <= 8'h39);
    assign par_evt  = rx_data_valid && rx_parity_error;
    assign rej_evt  = rx_data_valid && !rx_parity_error && !is_digit;
    assign cand     = rx_data_valid && !rx_parity_error && is_digit;
    assign pop      = key_valid && key_ready;
    // A full FIFO still takes a key when the head leaves in the same cycle.
    assign push     = cand && (!fifo_full || pop);
    assign ovf_evt  = cand && !push;

    always_comb begin
        occ_nxt = occ;
        unique case (1'b1)
            push && !pop: occ_nxt = occ + OCC_ONE;
            pop && !push: occ_nxt = occ - OCC_ONE;
            default:      occ_nxt = occ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            key_valid <= 1'b0;
            fifo_full <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            occ       <= occ_nxt;
            key_valid <= (occ_nxt != '0);
            fifo_full <= (occ_nxt == OCC_MAX);
            unique case (state)
                EMPTY: begin
                    if (push) state <= PARTIAL;
                end
                PARTIAL: begin
                    if (occ_nxt == OCC_MAX)  state <= FULL;
                    else if (occ_nxt == '0)  state <= EMPTY;
                end
                FULL: begin
                    if (pop && !push) state <= PARTIAL;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= rx_ascii[3:0];
    end

    assign key_value = key_valid ? mem[rd_ptr] : 4'd0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset || clr_stats) begin
            parity_err_cnt <= '0;
            reject_cnt     <= '0;
            overflow_cnt   <= '0;
        end else begin
            if (par_evt) parity_err_cnt <= sat_inc(parity_err_cnt);
            if (rej_evt) reject_cnt     <= sat_inc(reject_cnt);
            if (ovf_evt) overflow_cnt   <= sat_inc(overflow_cnt);
        end
    end

endmodule

// File: tb/tb_uart_key_decoder.sv
// Bench for uart_key_decoder: stimulus queues expected keys and status checks,
// a negedge monitor pops and compares them.
module tb_uart_key_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_ascii = 8'h00;
    logic       rx_parity_error = 1'b0;
    logic       rx_data_valid = 1'b0;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       fifo_full;
    logic       clr_stats = 1'b0;
    logic [7:0] parity_err_cnt;
    logic [7:0] reject_cnt;
    logic [7:0] overflow_cnt;

    typedef struct {
        string    name;
        bit       qchk;
        bit       v;
        bit       f;
        bit [7:0] p;
        bit [7:0] r;
        bit [7:0] o;
    } req_t;

    logic [3:0] exp_q[$];
    req_t       chk_q[$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    uart_key_decoder #(.DEPTH(4), .PTR_W(2), .CNT_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .rx_ascii(rx_ascii),
        .rx_parity_error(rx_parity_error),
        .rx_data_valid(rx_data_valid),
        .key_value(key_value),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .fifo_full(fifo_full),
        .clr_stats(clr_stats),
        .parity_err_cnt(parity_err_cnt),
        .reject_cnt(reject_cnt),
        .overflow_cnt(overflow_cnt)
    );

    always @(negedge clk) begin
        if (reset && key_valid && key_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL key_pop: got %0d, required no key", key_value);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_value !== e) begin
                    fails++;
                    $display("FAIL key_pop: got %0d, required %0d", key_value, e);
                end
            end
        end
        while (chk_q.size() > 0) begin
            req_t r;
            r = chk_q.pop_front();
            tests++;
            if (r.qchk) begin
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL %s: %0d keys undelivered, required 0",
                             r.name, exp_q.size());
                end
            end else if (key_valid !== r.v || fifo_full !== r.f ||
                         parity_err_cnt !== r.p || reject_cnt !== r.r ||
                         overflow_cnt !== r.o ||
                         (!r.v && key_value !== 4'd0)) begin
                fails++;
                $display("FAIL %s: got v=%b f=%b kv=%0d p=%0d r=%0d o=%0d, required v=%b f=%b p=%0d r=%0d o=%0d",
                         r.name, key_valid, fifo_full, key_value, parity_err_cnt,
                         reject_cnt, overflow_cnt, r.v, r.f, r.p, r.r, r.o);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b, input logic par, input logic clr);
        rx_ascii        = b;
        rx_parity_error = par;
        rx_data_valid   = 1'b1;
        clr_stats       = clr;
        @(posedge clk);
        #1;
        rx_data_valid   = 1'b0;
        rx_parity_error = 1'b0;
        clr_stats       = 1'b0;
    endtask

    task automatic req(input string n, input bit v, input bit f,
                       input int p, input int r, input int o);
        req_t q;
        q.name = n;
        q.qchk = 1'b0;
        q.v = v;
        q.f = f;
        q.p = p[7:0];
        q.r = r[7:0];
        q.o = o[7:0];
        chk_q.push_back(q);
    endtask

    initial begin
        req_t qe;
        int   budget;

        idle(2);
        reset = 1'b1;
        idle(1);
        req("reset", 0, 0, 0, 0, 0);

        key_ready = 1'b1;
        exp_q.push_back(4'd3);
        strobe(8'h33, 0, 0);
        req("lat3", 1, 0, 0, 0, 0);
        exp_q.push_back(4'd7);
        strobe(8'h37, 0, 0);
        req("lat7", 1, 0, 0, 0, 0);
        idle(2);
        req("after37", 0, 0, 0, 0, 0);

        strobe(8'h41, 0, 0);
        strobe(8'h2F, 0, 0);
        strobe(8'h3A, 0, 0);
        idle(1);
        req("reject3", 0, 0, 0, 3, 0);

        strobe(8'h35, 1, 0);
        idle(1);
        req("parity1", 0, 0, 1, 3, 0);
        strobe(8'h35, 1, 1);
        req("clr_wins", 0, 0, 0, 0, 0);

        key_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(4'(i));
            strobe(8'h30 + 8'(i), 0, 0);
        end
        idle(1);
        req("overflow", 1, 1, 0, 0, 1);
        key_ready = 1'b1;
        idle(6);
        req("drained", 0, 0, 0, 0, 1);

        key_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(4'(i));
            strobe(8'h30 + 8'(i), 0, 0);
        end
        idle(1);
        req("full_again", 1, 1, 0, 0, 1);
        exp_q.push_back(4'd9);
        key_ready = 1'b1;
        strobe(8'h39, 0, 0);
        req("push_pop_full", 1, 1, 0, 0, 1);
        idle(6);
        req("drained2", 0, 0, 0, 0, 1);

        key_ready = 1'b0;
        strobe(8'h36, 0, 0);
        strobe(8'h37, 0, 0);
        strobe(8'h38, 0, 0);
        req("queued3", 1, 0, 0, 0, 1);
        reset = 1'b0;
        strobe(8'h32, 0, 0);
        reset = 1'b1;
        req("mid_reset", 0, 0, 0, 0, 0);
        key_ready = 1'b1;

        for (int i = 0; i < 300; i++) strobe(8'h41, 0, 0);
        idle(1);
        req("reject_sat", 0, 0, 0, 255, 0);

        idle(2);
        qe.name = "queue_empty";
        qe.qchk = 1'b1;
        qe.v = 0;
        qe.f = 0;
        qe.p = 0;
        qe.r = 0;
        qe.o = 0;
        chk_q.push_back(qe);
        budget = 100;
        while (chk_q.size() > 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        if (chk_q.size() > 0) begin
            $display("FAIL monitor_timeout: %0d checks pending, required 0",
                     chk_q.size());
            $fatal(1, "monitor stalled");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
